// File: rtl/audio_pkg.sv
// Shared constants and types for the sawtooth audio path: sample/frequency
// widths, the phase-step -> Hz scaling, and the measurement FSM states.
package audio_pkg;

    localparam int FS_HZ             = 48000;
    localparam int SAMPLE_W          = 16;
    localparam int FREQ_W            = 24;
    localparam int PERIOD_W          = 16;
    localparam int PHASE_TO_HZ_SHIFT = 9;
    // FS_HZ / 2^SAMPLE_W expressed over 2^PHASE_TO_HZ_SHIFT; 48000/65536 == 375/512 exactly.
    localparam int PHASE_TO_HZ_NUM   = (FS_HZ * (1 << PHASE_TO_HZ_SHIFT)) / (1 << SAMPLE_W);

    typedef enum logic [1:0] {
        PRIME   = 2'd0,
        ACCUM   = 2'd1,
        COMPUTE = 2'd2
    } meas_state_e;

    // Phase advance between two samples; modulo arithmetic makes a sawtooth wrap free of error.
    function automatic logic [SAMPLE_W-1:0] sample_delta(input logic [SAMPLE_W-1:0] cur,
                                                         input logic [SAMPLE_W-1:0] prev);
        return cur - prev;
    endfunction

endpackage

// File: rtl/saw_freq_meas_pulse_watchdog.sv
// Strobe watchdog: counts clock cycles since the last sample strobe (or reset)
// and raises o_timeout while the quiet run has reached STALL_CYC cycles.
// A strobe arriving on the would-be timeout cycle suppresses the timeout.
module pulse_watchdog #(
    parameter int STALL_CYC = 2000
) (
    input  logic i_clk48,
    input  logic i_rst48,
    input  logic i_pulse,
    output logic o_timeout
);

    localparam int               CNT_W = $clog2(STALL_CYC + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(STALL_CYC - 1);

    logic [CNT_W-1:0] quiet_q;
    logic [CNT_W-1:0] quiet_d;
    logic             at_limit;

    // Next quiet count: restart on a strobe, otherwise climb and park at the limit.
    always_comb begin
        at_limit  = (quiet_q == LAST);
        quiet_d   = quiet_q;
        if (i_pulse) begin
            quiet_d = '0;
        end else if (!at_limit) begin
            quiet_d = quiet_q + CNT_W'(1);
        end
        o_timeout = at_limit && !i_pulse;
    end

    // Quiet-cycle counter register.
    always_ff @(posedge i_clk48) begin
        if (i_rst48) begin
            quiet_q <= '0;
        end else begin
            quiet_q <= quiet_d;
        end
    end

endmodule

// File: rtl/saw_freq_meas.sv
// Sawtooth frequency meter: averages 2^AVG_LOG2 modulo-2^16 sample deltas and
// converts the summed phase step back to Hz (x375 >> (9+AVG_LOG2)). Also reports
// sample wraps, the wrap-to-wrap period in samples, and a stalled strobe.
module saw_freq_meas
    import audio_pkg::*;
#(
    parameter int AVG_LOG2  = 3,
    parameter int STALL_CYC = 2000
) (
    input  logic                i_clk48,
    input  logic                i_rst48,
    input  logic [SAMPLE_W-1:0] i_sample,
    input  logic                i_pulse,
    output logic [FREQ_W-1:0]   o_freq,
    output logic                o_valid,
    output logic                o_wrap,
    output logic [PERIOD_W-1:0] o_period,
    output logic                o_stalled
);

    localparam int ACC_W     = SAMPLE_W + AVG_LOG2;
    localparam int PROD_W    = ACC_W + PHASE_TO_HZ_SHIFT;
    localparam int CNT_W     = AVG_LOG2 + 1;
    localparam int OUT_SHIFT = PHASE_TO_HZ_SHIFT + AVG_LOG2;

    localparam logic [CNT_W-1:0]             WIN_LEN  = CNT_W'(1 << AVG_LOG2);
    localparam logic [PHASE_TO_HZ_SHIFT-1:0] MUL_BITS = PHASE_TO_HZ_SHIFT'(PHASE_TO_HZ_NUM);

    meas_state_e         state_q, state_d;
    logic [SAMPLE_W-1:0] prev_q, prev_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [FREQ_W-1:0]   freq_q, freq_d;
    logic                valid_q, valid_d;
    logic                wrap_q, wrap_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] period_cnt_q, period_cnt_d;
    logic                armed_q, armed_d;
    logic                stalled_q, stalled_d;

    logic                timeout;
    logic [SAMPLE_W-1:0] delta;
    logic                is_wrap;
    logic                take_delta;
    logic [ACC_W-1:0]    acc_base;
    logic [CNT_W-1:0]    cnt_base;
    logic [PROD_W-1:0]   mul_part [PHASE_TO_HZ_SHIFT];
    logic [PROD_W-1:0]   product;
    logic [FREQ_W-1:0]   freq_calc;

    pulse_watchdog #(
        .STALL_CYC (STALL_CYC)
    ) u_watchdog (
        .i_clk48   (i_clk48),
        .i_rst48   (i_rst48),
        .i_pulse   (i_pulse),
        .o_timeout (timeout)
    );

    // Constant multiply by PHASE_TO_HZ_NUM as a sum of shifted copies of the accumulator.
    generate
        for (genvar gi = 0; gi < PHASE_TO_HZ_SHIFT; gi++) begin : g_mul
            if (MUL_BITS[gi]) begin : g_term
                assign mul_part[gi] = PROD_W'(acc_q) << gi;
            end else begin : g_zero
                assign mul_part[gi] = '0;
            end
        end
    endgenerate

    // Sum the partial products and scale the window total down to Hz.
    always_comb begin
        product = '0;
        for (int i = 0; i < PHASE_TO_HZ_SHIFT; i++) begin
            product = product + mul_part[i];
        end
        freq_calc = FREQ_W'(product >> OUT_SHIFT);
    end

    // Measurement FSM next state plus accumulation, wrap tracking and stall handling.
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        freq_d       = freq_q;
        valid_d      = 1'b0;
        wrap_d       = 1'b0;
        period_d     = period_q;
        period_cnt_d = period_cnt_q;
        armed_d      = armed_q;
        stalled_d    = stalled_q;
        take_delta   = 1'b0;
        acc_base     = acc_q;
        cnt_base     = cnt_q;
        delta        = sample_delta(i_sample, prev_q);
        is_wrap      = (i_sample < prev_q);

        if (timeout) begin
            // Strobe lost: drop the partial window and wait for a fresh prime.
            state_d   = PRIME;
            acc_d     = '0;
            cnt_d     = '0;
            armed_d   = 1'b0;
            stalled_d = 1'b1;
        end else begin
            case (state_q)
                PRIME: begin
                    armed_d = 1'b0;
                    if (i_pulse) begin
                        prev_d    = i_sample;
                        stalled_d = 1'b0;
                        state_d   = ACCUM;
                    end
                end
                ACCUM: begin
                    take_delta = i_pulse;
                end
                COMPUTE: begin
                    freq_d     = freq_calc;
                    valid_d    = 1'b1;
                    acc_base   = '0;
                    cnt_base   = '0;
                    acc_d      = '0;
                    cnt_d      = '0;
                    state_d    = ACCUM;
                    // A strobe here opens the next window instead of being lost.
                    take_delta = i_pulse;
                end
                default: begin
                    state_d = PRIME;
                end
            endcase

            if (take_delta) begin
                acc_d   = acc_base + ACC_W'(delta);
                cnt_d   = cnt_base + CNT_W'(1);
                prev_d  = i_sample;
                state_d = (cnt_d == WIN_LEN) ? COMPUTE : ACCUM;
                if (is_wrap) begin
                    wrap_d       = 1'b1;
                    // The first wrap after priming has no earlier wrap to measure from.
                    if (armed_q) begin
                        period_d = period_cnt_q;
                    end
                    period_cnt_d = PERIOD_W'(1);
                    armed_d      = 1'b1;
                end else if (period_cnt_q != '1) begin
                    period_cnt_d = period_cnt_q + PERIOD_W'(1);
                end
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge i_clk48) begin
        if (i_rst48) begin
            state_q      <= PRIME;
            prev_q       <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            freq_q       <= '0;
            valid_q      <= 1'b0;
            wrap_q       <= 1'b0;
            period_q     <= '0;
            period_cnt_q <= '0;
            armed_q      <= 1'b0;
            stalled_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            freq_q       <= freq_d;
            valid_q      <= valid_d;
            wrap_q       <= wrap_d;
            period_q     <= period_d;
            period_cnt_q <= period_cnt_d;
            armed_q      <= armed_d;
            stalled_q    <= stalled_d;
        end
    end

    assign o_freq    = freq_q;
    assign o_valid   = valid_q;
    assign o_wrap    = wrap_q;
    assign o_period  = period_q;
    assign o_stalled = stalled_q;

endmodule
